// File: rtl/ram_sdp.sv
`default_nettype none
// ============================================================================
// Module   : ram_sdp
// Purpose  : Simple-dual-port synchronous RAM with byte-lane writes, 1/2-cycle
//            read latency, selectable read-during-write and a clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sdp #(
  parameter int              AWID       = 8,
  parameter int              DWID       = 16,
  parameter int              RD_LAT     = 1,
  parameter int              RDW_MODE   = 0,
  parameter int              CLR_ON_RST = 1,
  parameter logic [DWID-1:0] CLR_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [DWID/8-1:0] i_be,
  input  logic [AWID-1:0]   i_waddr,
  input  logic [DWID-1:0]   i_wdat,
  input  logic              i_re,
  input  logic [AWID-1:0]   i_raddr,
  output logic [DWID-1:0]   o_rdat,
  output logic              o_rvld,
  input  logic              i_clr,
  output logic              o_busy
);

  localparam int              DEPTH       = 2**AWID;
  localparam int              NBYTE       = DWID/8;
  localparam logic [AWID-1:0] c_last_addr = AWID'(DEPTH-1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AWID-1:0]    r_cnt;
  logic [AWID-1:0]    w_cnt_nxt;

  logic [DWID-1:0]    r_mem [DEPTH];
  logic [NBYTE-1:0]   w_wen;
  logic [AWID-1:0]    w_waddr;
  logic [DWID-1:0]    w_wdat;

  logic               w_rd;
  logic [DWID-1:0]    w_rword;
  logic [DWID-1:0]    r_rdat1;
  logic               r_rvld1;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_clr) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + AWID'(1);
        if (r_cnt == c_last_addr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state == S_CLEAR);

  // ---------------------------------------------------------------- write port
  // The clear sequencer takes the write port over completely while busy.
  always_comb begin
    w_wen   = '0;
    w_waddr = i_waddr;
    w_wdat  = i_wdat;
    if (r_state == S_CLEAR) begin
      w_wen   = '1;
      w_waddr = r_cnt;
      w_wdat  = CLR_VAL;
    end else if (i_we) begin
      w_wen   = i_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTE; b++) begin
      if (w_wen[b]) r_mem[w_waddr][8*b +: 8] <= w_wdat[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------- read port
  assign w_rd = (r_state == S_IDLE) && i_re;

  generate
    if (RDW_MODE != 0) begin : g_rdw_new
      always_comb begin
        w_rword = r_mem[i_raddr];
        for (int b = 0; b < NBYTE; b++) begin
          if (w_wen[b] && (w_waddr == i_raddr)) w_rword[8*b +: 8] = w_wdat[8*b +: 8];
        end
      end
    end else begin : g_rdw_old
      assign w_rword = r_mem[i_raddr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdat1 <= '0;
      r_rvld1 <= 1'b0;
    end else begin
      r_rvld1 <= w_rd;
      if (w_rd) r_rdat1 <= w_rword;
    end
  end

  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic [DWID-1:0] r_rdat2;
      logic            r_rvld2;

      // Second stage only loads on valid data so the output holds between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdat2 <= '0;
          r_rvld2 <= 1'b0;
        end else begin
          r_rvld2 <= r_rvld1;
          if (r_rvld1) r_rdat2 <= r_rdat1;
        end
      end

      assign o_rdat = r_rdat2;
      assign o_rvld = r_rvld2;
    end else begin : g_lat1
      assign o_rdat = r_rdat1;
      assign o_rvld = r_rvld1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sdp
// Purpose  : Directed bench for ram_sdp: three configurations on shared inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sdp;

  localparam int              AW   = 4;
  localparam int              DW   = 16;
  localparam int              NB   = DW/8;
  localparam logic [DW-1:0]   CV_C = 16'hC1C1;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_n_c;
  logic          we, re, clr;
  logic [NB-1:0] be;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat_a, rdat_b, rdat_c;
  logic          rvld_a, rvld_b, rvld_c;
  logic          busy_a, busy_b, busy_c;

  // A: latency 1, old-data; B: latency 2, new-data; C: no auto-clear, CLR_VAL C1C1
  ram_sdp #(.AWID(AW), .DWID(DW), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1), .CLR_VAL(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdat(wdat),
    .i_re(re), .i_raddr(raddr), .o_rdat(rdat_a), .o_rvld(rvld_a), .i_clr(clr), .o_busy(busy_a));
  ram_sdp #(.AWID(AW), .DWID(DW), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1), .CLR_VAL(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdat(wdat),
    .i_re(re), .i_raddr(raddr), .o_rdat(rdat_b), .o_rvld(rvld_b), .i_clr(clr), .o_busy(busy_b));
  ram_sdp #(.AWID(AW), .DWID(DW), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(0), .CLR_VAL(CV_C)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .i_we(we), .i_be(be), .i_waddr(waddr), .i_wdat(wdat),
    .i_re(re), .i_raddr(raddr), .o_rdat(rdat_c), .o_rvld(rvld_c), .i_clr(clr), .o_busy(busy_c));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_in();
    we = 1'b0; be = '0; waddr = '0; wdat = '0; re = 1'b0; raddr = '0; clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_in();
    we = 1'b1; be = 2'b11; waddr = a; wdat = d;
    step();
  endtask

  function automatic logic [DW-1:0] pat1(input int i);
    return (i == 0) ? 16'h8000 : 16'(i);
  endfunction

  function automatic logic [DW-1:0] pat2(input int i);
    return 16'h3000 + 16'(i);
  endfunction

  // One record per clock: inputs, then A and B outputs expected after that edge
  typedef struct {
    logic          we;
    logic [1:0]    be;
    logic [3:0]    wa;
    logic [15:0]   wd;
    logic          re;
    logic [3:0]    ra;
    logic          va;
    logic [15:0]   da;
    logic          vb;
    logic [15:0]   db;
  } vec_t;

  function automatic vec_t v(input logic we_i, input logic [1:0] be_i, input logic [3:0] wa,
                             input logic [15:0] wd, input logic re_i, input logic [3:0] ra,
                             input logic va, input logic [15:0] da, input logic vb,
                             input logic [15:0] db);
    vec_t r;
    r.we = we_i; r.be = be_i; r.wa = wa; r.wd = wd; r.re = re_i; r.ra = ra;
    r.va = va; r.da = da; r.vb = vb; r.db = db;
    return r;
  endfunction

  localparam int NV = 35;
  vec_t tv [NV];

  initial begin
    int n;
    int bad_a;
    int bad_b;

    for (int i = 0; i < 16; i++)
      tv[i] = v(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 16'h0, (i != 0), 16'h0);
    tv[16] = v(1'b1, 2'b11, 4'd3, 16'hA5C3, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    tv[17] = v(1'b1, 2'b01, 4'd3, 16'h1177, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    tv[18] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'hA577, 1'b0, 16'h0000);
    tv[19] = v(1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b0, 16'hA577, 1'b1, 16'hA577);
    tv[20] = v(1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b1, 4'd5, 1'b1, 16'h1234, 1'b0, 16'hA577);
    tv[21] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF);
    tv[22] = v(1'b1, 2'b10, 4'd9, 16'h55AA, 1'b1, 4'd9, 1'b1, 16'h0000, 1'b1, 16'hBEEF);
    tv[23] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b1, 16'h5500, 1'b1, 16'h5500);
    tv[24] = v(1'b1, 2'b11, 4'd0, 16'h0010, 1'b0, 4'd0, 1'b0, 16'h5500, 1'b1, 16'h5500);
    tv[25] = v(1'b1, 2'b11, 4'd1, 16'h0011, 1'b0, 4'd0, 1'b0, 16'h5500, 1'b0, 16'h5500);
    tv[26] = v(1'b1, 2'b11, 4'd2, 16'h0012, 1'b0, 4'd0, 1'b0, 16'h5500, 1'b0, 16'h5500);
    tv[27] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0010, 1'b0, 16'h5500);
    tv[28] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd1, 1'b1, 16'h0011, 1'b1, 16'h0010);
    tv[29] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1, 16'h0012, 1'b1, 16'h0011);
    tv[30] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0012, 1'b1, 16'h0012);
    tv[31] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0012, 1'b0, 16'h0012);
    tv[32] = v(1'b1, 2'b00, 4'd2, 16'hFFFF, 1'b0, 4'd0, 1'b0, 16'h0012, 1'b0, 16'h0012);
    tv[33] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1, 16'h0012, 1'b0, 16'h0012);
    tv[34] = v(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0012, 1'b1, 16'h0012);

    // ---- reset state
    rst_n = 1'b0; rst_n_c = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_busy_a", busy_a, 1'b1);
    chk_b("rst_busy_b", busy_b, 1'b1);
    chk_b("rst_busy_c", busy_c, 1'b0);
    chk_b("rst_rvld_a", rvld_a, 1'b0);
    chk_b("rst_rvld_b", rvld_b, 1'b0);
    chk_w("rst_rdat_a", rdat_a, 16'h0);
    chk_w("rst_rdat_b", rdat_b, 16'h0);

    // ---- auto-clear after reset lasts DEPTH cycles
    @(negedge clk);
    rst_n = 1'b1; rst_n_c = 1'b1;
    #1;
    n = busy_a ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!busy_a) break;
      n++;
    end
    chk_i("auto_clear_cycles", n, 16);
    chk_b("auto_clear_busy_b", busy_b, 1'b0);

    // ---- table-driven vectors
    for (int i = 0; i < NV; i++) begin
      we = tv[i].we; be = tv[i].be; waddr = tv[i].wa; wdat = tv[i].wd;
      re = tv[i].re; raddr = tv[i].ra; clr = 1'b0;
      step();
      chk_b($sformatf("vec%0d_rvld_a", i), rvld_a, tv[i].va);
      chk_w($sformatf("vec%0d_rdat_a", i), rdat_a, tv[i].da);
      chk_b($sformatf("vec%0d_rvld_b", i), rvld_b, tv[i].vb);
      chk_w($sformatf("vec%0d_rdat_b", i), rdat_b, tv[i].db);
    end
    idle_in();
    step();

    // ---- clear with a concurrent read, traffic ignored while busy
    for (int i = 0; i < 16; i++) wr(4'(i), pat1(i));
    idle_in();
    clr = 1'b1; re = 1'b1; raddr = 4'd7;
    step();
    chk_b("clr_rd_rvld_a", rvld_a, 1'b1);
    chk_w("clr_rd_rdat_a", rdat_a, 16'h0007);
    n = busy_a ? 1 : 0;
    bad_a = 0; bad_b = 0;
    we = 1'b1; be = 2'b11; waddr = 4'd4; wdat = 16'hFFFF; re = 1'b1; raddr = 4'd4; clr = 1'b1;
    for (int k = 1; k < 100; k++) begin
      step();
      if (k == 1) begin
        chk_b("clr_rd_rvld_b", rvld_b, 1'b1);
        chk_w("clr_rd_rdat_b", rdat_b, 16'h0007);
      end else if (rvld_b) begin
        bad_b++;
      end
      if (rvld_a) bad_a++;
      if (!busy_a) break;
      n++;
    end
    idle_in();
    chk_i("clr_busy_cycles", n, 16);
    chk_i("clr_rvld_a_while_busy", bad_a, 0);
    chk_i("clr_rvld_b_while_busy", bad_b, 0);
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; raddr = 4'(i);
      step();
      chk_b($sformatf("post_clr_rvld_a%0d", i), rvld_a, 1'b1);
      chk_w($sformatf("post_clr_rdat_a%0d", i), rdat_a, 16'h0000);
      chk_w($sformatf("post_clr_rdat_c%0d", i), rdat_c, CV_C);
    end
    idle_in();
    step();

    // ---- reset during clear on the no-auto-clear instance
    for (int i = 0; i < 16; i++) wr(4'(i), pat2(i));
    idle_in();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n_c = 1'b0;
    #1;
    chk_b("midrst_busy_c", busy_c, 1'b0);
    chk_b("midrst_rvld_c", rvld_c, 1'b0);
    chk_w("midrst_rdat_c", rdat_c, 16'h0000);
    @(negedge clk);
    rst_n_c = 1'b1;
    n = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
    end
    chk_b("midrst_a_done", busy_a, 1'b0);
    chk_b("midrst_busy_c_after", busy_c, 1'b0);
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; raddr = 4'(i);
      step();
      chk_b($sformatf("midrst_rvld_c%0d", i), rvld_c, 1'b1);
      chk_w($sformatf("midrst_rdat_c%0d", i), rdat_c, (i < 5) ? CV_C : pat2(i));
    end
    idle_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
